seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 192 +++++++++++++++++++
 tb/tb_seg7_scan.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 4-digit common-anode seven-segment driver.
//
// A 14-bit value is captured on a load strobe into a shadow register and
// promoted to the displayed value only at a frame boundary (after digit 3
// has been shown). Each frame therefore shows one consistent value.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit is shown (2 .. 2^20)
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   value[13:0] binary value, captured when load=1
//   load        single-cycle capture strobe
//   blank_lz    1 = blank leading zero digits (digit 0 always shown)
//   an[3:0]     registered digit enables, active-low, an[0] = LS digit
//   seg[6:0]    registered segments {g,f,e,d,c,b,a}, active-low
//   pending     a captured value is waiting for the next frame boundary
//   frame_done  one-cycle pulse in the cycle after each frame boundary
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned VAL_W   = 14;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(3);
  localparam logic [AN_W-1:0]    AN_OFF     = 4'hF;
  localparam logic [SEG_W-1:0]   SEG_OFF    = 7'h7F;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] h);
    logic [SEG_W-1:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit index to active-low one-hot anode enable.
  function automatic logic [AN_W-1:0] idx_to_an(input logic [IDX_W-1:0] i);
    logic [AN_W-1:0] a;
    case (i)
      2'd0:    a = 4'hE;
      2'd1:    a = 4'hD;
      2'd2:    a = 4'hB;
      default: a = 4'h7;
    endcase
    return a;
  endfunction

  // State registers
  logic [PRESC_W-1:0] presc_q,      presc_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [VAL_W-1:0]   disp_q,       disp_d;
  logic [VAL_W-1:0]   shadow_q,     shadow_d;
  logic               pending_q,    pending_d;
  logic               frame_done_q, frame_done_d;
  logic [AN_W-1:0]    an_q,         an_d;
  logic [SEG_W-1:0]   seg_q,        seg_d;

  // Combinational helpers
  logic             tick;
  logic             boundary;
  logic [3:0]       digit [4];
  logic [3:0]       digit_zero;
  logic [3:0]       blank_vec;
  logic [3:0]       cur_digit;
  logic             cur_blank;

  // Prescaler terminal count and frame boundary.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = tick && (idx_q == IDX_LAST);
  end

  // Scan timing: prescaler wraps at REFRESH_DIV-1, idx advances on tick.
  always_comb begin
    presc_d      = presc_q + PRESC_W'(1);
    idx_d        = idx_q;
    frame_done_d = boundary;
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // Double buffer: disp only moves at a boundary, so a frame never mixes
  // two values. A load exactly on the boundary bypasses the shadow.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (load && boundary) begin
      shadow_d  = value;
      disp_d    = value;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Digit split and leading-zero blanking of the displayed value.
  always_comb begin
    digit[0] = disp_q[3:0];
    digit[1] = disp_q[7:4];
    digit[2] = disp_q[11:8];
    digit[3] = {2'b00, disp_q[13:12]};
    for (int k = 0; k < 4; k++) begin
      digit_zero[k] = (digit[k] == 4'h0);
    end
    // Digit k blanks only if it and every higher digit are zero.
    blank_vec[3] = blank_lz && digit_zero[3];
    blank_vec[2] = blank_vec[3] && digit_zero[2];
    blank_vec[1] = blank_vec[2] && digit_zero[1];
    blank_vec[0] = 1'b0;
  end

  // Output path: anode/segment image for the currently selected digit.
  always_comb begin
    cur_digit = digit[idx_q];
    cur_blank = blank_vec[idx_q];
    an_d      = idx_to_an(idx_q);
    seg_d     = hex_to_seg(cur_digit);
    if (cur_blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State register with synchronous reset; reset also discards any load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan with REFRESH_DIV=4 (16-cycle frames).
// Expected digit images are queued when a value is loaded and popped as
// each digit of the following frame appears on an/seg.
module tb_seg7_scan;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [6:0] enc(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  function automatic exp_t exp_digit(input logic [13:0] v, input int k, input bit blz);
    logic [3:0] d [4];
    logic [3:0] an_tab [4];
    bit         blank;
    exp_t       r;
    d[0] = v[3:0];
    d[1] = v[7:4];
    d[2] = v[11:8];
    d[3] = {2'b00, v[13:12]};
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    blank = 1'b0;
    if (blz && k > 0) begin
      blank = 1'b1;
      for (int j = k; j < 4; j++) if (d[j] != 4'h0) blank = 1'b0;
    end
    r.an  = blank ? 4'hF : an_tab[k];
    r.seg = blank ? 7'h7F : enc(d[k]);
    return r;
  endfunction

  task automatic push_frame(input logic [13:0] v, input bit blz);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_digit(v, k, blz));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Advance to the next cycle in which frame_done is high (bounded).
  task automatic wait_fd(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: frame_done not seen within 40 cycles", name);
    end
  endtask

  task automatic check_digit(input string name, input int k);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s digit%0d: scoreboard empty, got an=%h seg=%h", name, k, an, seg);
    end else begin
      e = exp_q.pop_front();
      if ({an, seg} !== {e.an, e.seg}) begin
        failures++;
        $display("FAIL %s digit%0d: got an=%h seg=%h expected an=%h seg=%h",
                 name, k, an, seg, e.an, e.seg);
      end
    end
  endtask

  // Called in a frame_done cycle: checks the four digits of the new frame.
  task automatic capture_frame(input string name);
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_done_width: got %b expected 0", name, frame_done);
    end
    check_digit(name, 0);
    for (int k = 1; k < 4; k++) begin
      repeat (DIV) step();
      check_digit(name, k);
    end
  endtask

  task automatic check_pending(input string name, input logic exp);
    checks++;
    if (pending !== exp) begin
      failures++;
      $display("FAIL %s pending: got %b expected %b", name, pending, exp);
    end
  endtask

  // Reset overrides a simultaneous load; then idle scan of disp=0.
  task automatic test_reset();
    rst_n = 1'b0;
    blank_lz = 1'b0;
    value = 14'h1234;
    load  = 1'b1;
    repeat (3) step();
    load = 1'b0;
    checks++;
    if ({an, seg, pending, frame_done} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got an=%h seg=%h pend=%b fd=%b expected an=F seg=7F pend=0 fd=0",
               an, seg, pending, frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int n = 0; n < 32; n++) exp_q.push_back(exp_digit(14'h0000, (n / DIV) % 4, 1'b0));
    for (int n = 1; n <= 32; n++) begin
      step();
      check_digit("idle_scan", (n - 1) / DIV % 4);
      checks++;
      if (frame_done !== ((n % 16) == 0)) begin
        failures++;
        $display("FAIL idle_frame_done cycle%0d: got %b expected %b", n, frame_done, (n % 16) == 0);
      end
    end
    check_pending("idle_scan", 1'b0);
  endtask

  task automatic test_load_midframe();
    wait_fd("load_mid");
    repeat (2) step();
    do_load(14'h2A5C);
    check_pending("load_mid_after_load", 1'b1);
    repeat (5) step();
    check_pending("load_mid_hold", 1'b1);
    push_frame(14'h2A5C, 1'b0);
    wait_fd("load_mid");
    check_pending("load_mid_boundary", 1'b0);
    capture_frame("load_mid");
  endtask

  task automatic test_last_load_wins();
    wait_fd("last_wins");
    step();
    do_load(14'h0001);
    step();
    do_load(14'h0003);
    check_pending("last_wins", 1'b1);
    push_frame(14'h0003, 1'b0);
    wait_fd("last_wins");
    capture_frame("last_wins");
  endtask

  task automatic test_blank_lz();
    blank_lz = 1'b1;
    wait_fd("blank_zero");
    step();
    do_load(14'h0000);
    push_frame(14'h0000, 1'b1);
    wait_fd("blank_zero");
    capture_frame("blank_zero");
    do_load(14'h0100);
    push_frame(14'h0100, 1'b1);
    wait_fd("blank_0100");
    capture_frame("blank_0100");
    blank_lz = 1'b0;
  endtask

  // Load driven in the boundary cycle itself (presc=3, idx=3).
  task automatic test_load_on_boundary();
    wait_fd("load_boundary");
    repeat (15) step();
    do_load(14'h1F3E);
    check_pending("load_boundary", 1'b0);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL load_boundary frame_done: got %b expected 1", frame_done);
    end
    push_frame(14'h1F3E, 1'b0);
    capture_frame("load_boundary");
    check_pending("load_boundary_after", 1'b0);
  endtask

  task automatic test_reset_midframe();
    wait_fd("reset_mid");
    repeat (2) step();
    do_load(14'h0ABC);
    check_pending("reset_mid_load", 1'b1);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({an, seg, pending, frame_done} !== {4'hF, 7'h7F, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_state: got an=%h seg=%h pend=%b fd=%b expected an=F seg=7F pend=0 fd=0",
               an, seg, pending, frame_done);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({an, seg} !== {4'hE, 7'h40}) begin
      failures++;
      $display("FAIL reset_mid_first: got an=%h seg=%h expected an=E seg=40", an, seg);
    end
    push_frame(14'h0000, 1'b0);
    wait_fd("reset_mid");
    check_pending("reset_mid_frame", 1'b0);
    capture_frame("reset_mid");
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_last_load_wins();
    test_blank_lz();
    test_load_on_boundary();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
